// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit holding the architectural HI/LO pair.
// Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiply and divide run
// one bit per cycle over a shared 64-bit work register and are followed by a
// FIX cycle that applies the result signs.
//
// Optional build macro MDU_FAST_MUL_EN: when defined, MULT/MULTU complete in a
// single edge using a full 64-bit product and the iterative MUL state is
// removed; division is unaffected.
module mdu_hilo (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifndef MDU_FAST_MUL_EN
        ST_MUL  = 2'd1,
`endif
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    state_t      state_q;
    logic [5:0]  count_q;
    logic [63:0] work_q;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd_q;      // multiplicand or divisor magnitude
    logic        res_neg_q;   // negate product / quotient in FIX
    logic        rem_neg_q;   // negate remainder in FIX
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        dbz_q;
`ifndef MDU_FAST_MUL_EN
    logic        is_div_q;    // selects the FIX sign rule
`endif

    // Operand magnitudes and sign flags for the request being accepted
    logic        signed_op;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        res_neg_d;
    logic        rem_neg_d;

    // Decode signedness and take absolute values of the incoming operands
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        mag_a     = (signed_op && operand_a[31]) ? (~operand_a + 32'd1) : operand_a;
        mag_b     = (signed_op && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;
        res_neg_d = signed_op && (operand_a[31] ^ operand_b[31]);
        rem_neg_d = signed_op && operand_a[31];
    end

`ifdef MDU_FAST_MUL_EN
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] fast_prod;

    // Single-cycle product: extend operands to 64 bits so one unsigned
    // multiply truncated to 64 bits yields both signed and unsigned results
    always_comb begin
        ext_a     = signed_op ? {{32{operand_a[31]}}, operand_a} : {32'd0, operand_a};
        ext_b     = signed_op ? {{32{operand_b[31]}}, operand_b} : {32'd0, operand_b};
        fast_prod = ext_a * ext_b;
    end
`else
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    // One shift-add step: add multiplicand when the current multiplier LSB is
    // set, then shift the whole accumulator right keeping the carry
    always_comb begin
        mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
        mul_next = {mul_sum, work_q[31:1]};
    end
`endif

    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;

    // One restoring-division step: shift the remainder left by one dividend
    // bit and subtract the divisor if it fits, recording the quotient bit.
    // The shifted remainder is below twice the divisor, so a 33-bit
    // difference has its top bit set exactly when the subtraction fails.
    always_comb begin
        div_shift = work_q[63:31];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (!div_diff[32]) begin
            div_next = {div_diff[31:0], work_q[30:0], 1'b1};
        end else begin
            div_next = {work_q[62:31], work_q[30:0], 1'b0};
        end
    end

    logic [31:0] fix_hi_d;
    logic [31:0] fix_lo_d;
`ifndef MDU_FAST_MUL_EN
    logic [63:0] prod_fix;
`endif

    // Apply result signs to the finished magnitude before it lands in HI/LO
    always_comb begin
`ifndef MDU_FAST_MUL_EN
        prod_fix = res_neg_q ? (~work_q + 64'd1) : work_q;
        if (!is_div_q) begin
            fix_hi_d = prod_fix[63:32];
            fix_lo_d = prod_fix[31:0];
        end else begin
            fix_hi_d = rem_neg_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];
            fix_lo_d = res_neg_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
        end
`else
        fix_hi_d = rem_neg_q ? (~work_q[63:32] + 32'd1) : work_q[63:32];
        fix_lo_d = res_neg_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
`endif
    end

    // Control FSM with registered status outputs and the HI/LO pair
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= 6'd0;
            work_q    <= 64'd0;
            opnd_q    <= 32'd0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
`ifndef MDU_FAST_MUL_EN
            is_div_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: begin
                                hi_q   <= operand_a;
                                done_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q   <= operand_a;
                                done_q <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (operand_b == 32'd0) begin
                                    hi_q   <= operand_a;
                                    lo_q   <= 32'hFFFF_FFFF;
                                    done_q <= 1'b1;
                                    dbz_q  <= 1'b1;
                                end else begin
                                    work_q    <= {32'd0, mag_a};
                                    opnd_q    <= mag_b;
                                    res_neg_q <= res_neg_d;
                                    rem_neg_q <= rem_neg_d;
                                    count_q   <= 6'd0;
                                    busy_q    <= 1'b1;
`ifndef MDU_FAST_MUL_EN
                                    is_div_q  <= 1'b1;
`endif
                                    state_q   <= ST_DIV;
                                end
                            end
                            OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                                hi_q   <= fast_prod[63:32];
                                lo_q   <= fast_prod[31:0];
                                done_q <= 1'b1;
`else
                                work_q    <= {32'd0, mag_b};
                                opnd_q    <= mag_a;
                                res_neg_q <= res_neg_d;
                                rem_neg_q <= 1'b0;
                                count_q   <= 6'd0;
                                busy_q    <= 1'b1;
                                is_div_q  <= 1'b0;
                                state_q   <= ST_MUL;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
`ifndef MDU_FAST_MUL_EN
                ST_MUL: begin
                    work_q  <= mul_next;
                    count_q <= count_q + 6'd1;
                    if (count_q == 6'd31) begin
                        state_q <= ST_FIX;
                    end
                end
`endif
                ST_DIV: begin
                    work_q  <= div_next;
                    count_q <= count_q + 6'd1;
                    if (count_q == 6'd31) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed table of operations with hand-computed HI/LO results,
// plus hand-written sequences for back-to-back, ignored start and reset abort.
module tb_mdu_hilo;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;

    localparam int DIV_EDGES = 34;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_EDGES = 1;
`else
    localparam int MUL_EDGES = 34;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    mdu_hilo dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
        int          edges;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Issue one request, then wait (bounded) for done; reports edges from
    // request to done sample, busy samples seen, and stray div_by_zero.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_n, output int stray);
        @(negedge clock);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clock); #1;
        start = 1'b0;
        edges = 1; busy_n = 0; stray = 0;
        while (!done && edges < 60) begin
            if (busy) busy_n++;
            if (div_by_zero) stray++;
            @(posedge clock); #1;
            edges++;
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int edges, busy_n, stray;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, MUL_EDGES};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MUL_EDGES};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, DIV_EDGES};
        vecs[3]  = '{OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 1};
        vecs[4]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, DIV_EDGES};
        vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, DIV_EDGES};
        vecs[6]  = '{OP_MULT,  32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b0, MUL_EDGES};
        vecs[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, MUL_EDGES};
        vecs[8]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, MUL_EDGES};
        vecs[9]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, DIV_EDGES};
        vecs[10] = '{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0, DIV_EDGES};
        vecs[11] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, DIV_EDGES};
        vecs[12] = '{OP_DIVU,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         32'd1,         1'b0, DIV_EDGES};
        vecs[13] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'd1,         32'h2345_6780, 1'b0, MUL_EDGES};
        vecs[14] = '{OP_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 1};
        vecs[15] = '{OP_MTHI,  32'hCAFE_BABE, 32'd0,         32'hCAFE_BABE, 32'hFFFF_FFFF, 1'b0, 1};
        vecs[16] = '{OP_MTLO,  32'h1357_9BDF, 32'd9,         32'hCAFE_BABE, 32'h1357_9BDF, 1'b0, 1};
        vecs[17] = '{OP_DIVU,  32'd1000,      32'd1000,      32'd0,         32'd1,         1'b0, DIV_EDGES};

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven operations
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, edges, busy_n, stray);
            check($sformatf("v%0d_edges", i), edges, vecs[i].edges);
            check($sformatf("v%0d_busy", i), busy_n, vecs[i].edges - 1);
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            check($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].exp_dbz});
            check($sformatf("v%0d_stray_dbz", i), stray, 0);
            @(posedge clock); #1;
            check($sformatf("v%0d_done_width", i), {31'd0, done}, 32'd0);
            $display("op %0d a=%h b=%h -> hi=%h lo=%h dbz=%0d edges=%0d", i,
                     vecs[i].a, vecs[i].b, hi, lo, div_by_zero, edges);
        end

        // No-op opcode: nothing changes, no done
        @(negedge clock);
        start = 1'b1; op = OP_NOP; operand_a = 32'h5555_5555;
        @(posedge clock); #1;
        start = 1'b0;
        check("nop_done", {31'd0, done}, 32'd0);
        check("nop_hi", hi, 32'd0);
        check("nop_busy", {31'd0, busy}, 32'd0);
        $display("nop -> hi=%h lo=%h done=%0d", hi, lo, done);

        // MTHI then MTLO on consecutive cycles
        @(negedge clock);
        start = 1'b1; op = OP_MTHI; operand_a = 32'h1234_5678;
        @(posedge clock); #1;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_done", {31'd0, done}, 32'd1);
        @(negedge clock);
        op = OP_MTLO; operand_a = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        start = 1'b0;
        check("mtlo_lo", lo, 32'hDEAD_BEEF);
        check("mtlo_hi", hi, 32'h1234_5678);
        check("mtlo_done", {31'd0, done}, 32'd1);
        check("mtlo_busy", {31'd0, busy}, 32'd0);
        @(posedge clock); #1;
        check("mtlo_done_width", {31'd0, done}, 32'd0);
        $display("mthi/mtlo -> hi=%h lo=%h", hi, lo);

        // Start pulsed mid-DIV is ignored
        @(negedge clock);
        start = 1'b1; op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        start = 1'b1; op = OP_MTHI; operand_a = 32'h0000_0BAD;
        @(posedge clock); #1;
        start = 1'b0;
        check("ign_hi_mid", hi, 32'h1234_5678);
        wait_done("ign_timeout");
        check("ign_hi", hi, 32'd2);
        check("ign_lo", lo, 32'd14);
        $display("ignored start -> hi=%h lo=%h", hi, lo);

        // Zero-bubble: new request accepted in the done cycle
        @(negedge clock);
        start = 1'b1; op = OP_DIVU; operand_a = 32'd50; operand_b = 32'd8;
        @(posedge clock); #1;
        start = 1'b0;
        wait_done("b2b_timeout");
        check("b2b_first_lo", lo, 32'd6);
        @(negedge clock);
        start = 1'b1; op = OP_MTLO; operand_a = 32'h0000_0055;
        @(posedge clock); #1;
        start = 1'b0;
        check("b2b_lo", lo, 32'h0000_0055);
        check("b2b_hi", hi, 32'd2);
        check("b2b_done", {31'd0, done}, 32'd1);
        $display("back-to-back -> hi=%h lo=%h", hi, lo);

        // Reset at iteration 10 aborts the operation
        @(negedge clock);
        start = 1'b1;
`ifdef MDU_FAST_MUL_EN
        op = OP_DIVU;
`else
        op = OP_MULT;
`endif
        operand_a = 32'hFFFF_FFFF; operand_b = 32'h0000_0003;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        begin
            int done_seen;
            done_seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clock); #1;
                if (done || busy) done_seen++;
            end
            check("abort_no_done", done_seen, 0);
        end
        $display("reset abort -> hi=%h lo=%h busy=%0d", hi, lo, busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
